// File: rtl/prim_ram_ctrl_pkg.sv
// Shared types, constants and the byte-merge helper for the single-port RAM
// read-modify-write controller.
package prim_ram_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    RMW_RD = 1'b1
  } ctrl_state_e;

  localparam int unsigned RspDepth   = 2;
  localparam int unsigned MergeMaxW  = 256;
  localparam int unsigned MergeMaxMw = MergeMaxW / 8;

  // Per-byte select of new write data over the old RAM word; narrower callers zero-extend.
  function automatic logic [MergeMaxW-1:0] byte_merge(
    input logic [MergeMaxW-1:0]  wdata,
    input logic [MergeMaxW-1:0]  rdata,
    input logic [MergeMaxMw-1:0] mask
  );
    logic [MergeMaxW-1:0] merged;
    merged = rdata;
    for (int i = 0; i < int'(MergeMaxMw); i++) begin
      if (mask[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        merged[8*i +: 8] = rdata[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/prim_ram_ctrl_rsp_fifo.sv
// Two-entry response FIFO; the head is always a register, so a push into an
// empty FIFO becomes visible on the following cycle.
module prim_ram_ctrl_rsp_fifo
  import prim_ram_ctrl_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_r [RspDepth];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // When full, a push may only land in the slot being popped this cycle.
  assign pop_ok_s  = pop_i & (count_r != 2'd0);
  assign push_ok_s = push_i & ((count_r != 2'(RspDepth)) | pop_ok_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(RspDepth); i++) begin
        mem_r[i] <= {Width{1'b0}};
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data_i;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign valid_o = (count_r != 2'd0);
  assign data_o  = mem_r[rd_ptr_r];
  assign count_o = count_r;

endmodule

// File: rtl/prim_ram_1p_rmw_ctrl.sv
// Host request front-end for a single-port RAM: partial writes become read-modify-write,
// read data returns in order. Optional write acknowledgements under RAM_CTRL_WRITE_ACK_EN.
module prim_ram_1p_rmw_ctrl
  import prim_ram_ctrl_pkg::*;
#(
  parameter  int unsigned Width = 32,
  parameter  int unsigned Depth = 256,
  localparam int unsigned Aw    = $clog2(Depth),
  localparam int unsigned Mw    = Width / 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [Aw-1:0]    req_addr_i,
  input  logic [Width-1:0] req_wdata_i,
  input  logic [Mw-1:0]    req_wmask_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [Width-1:0] rsp_rdata_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  input  logic [Width-1:0] ram_rdata_i
);

`ifdef RAM_CTRL_WRITE_ACK_EN
  localparam logic WriteAckEn = 1'b1;
`else
  localparam logic WriteAckEn = 1'b0;
`endif

  ctrl_state_e      state_r, state_s;
  logic             run_r;
  logic [Aw-1:0]    addr_r;
  logic [Width-1:0] wdata_r;
  logic [Mw-1:0]    mask_r;
  logic             inflight_r;
  logic             inflight_rd_r;
  logic             full_mask_s, zero_mask_s, partial_s, need_rsp_s;
  logic             credit_ok_s, accept_s, push_s, pop_s;
  logic [1:0]       count_s;
  logic [Width-1:0] merged_s, push_data_s;

  assign full_mask_s = (req_wmask_i == {Mw{1'b1}});
  assign zero_mask_s = (req_wmask_i == {Mw{1'b0}});
  assign partial_s   = req_write_i & ~full_mask_s & ~zero_mask_s;
  assign need_rsp_s  = ~req_write_i | WriteAckEn;
  assign pop_s       = rsp_valid_o & rsp_ready_i;
  // A slot freed by this cycle's pop is usable, which keeps streaming reads bubble-free.
  assign credit_ok_s = (3'(count_s) + 3'(inflight_r) + 3'(need_rsp_s)) <= (3'(RspDepth) + 3'(pop_s));
  assign accept_s    = req_valid_i & req_ready_o;
  assign merged_s    = Width'(byte_merge(MergeMaxW'(wdata_r), MergeMaxW'(ram_rdata_i), MergeMaxMw'(mask_r)));
  assign push_s      = inflight_r | ((state_r == RMW_RD) & WriteAckEn);
  assign push_data_s = inflight_rd_r ? ram_rdata_i : {Width{1'b0}};

  // Next state, request acceptance and the RAM command for this cycle.
  always_comb begin
    state_s     = state_r;
    req_ready_o = 1'b0;
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = {Aw{1'b0}};
    ram_wdata_o = {Width{1'b0}};
    case (state_r)
      IDLE: begin
        req_ready_o = run_r & credit_ok_s;
        if (req_valid_i && run_r && credit_ok_s) begin
          if (!req_write_i || partial_s) begin
            ram_req_o  = 1'b1;
            ram_addr_o = req_addr_i;
            state_s    = partial_s ? RMW_RD : IDLE;
          end else if (full_mask_s) begin
            ram_req_o   = 1'b1;
            ram_write_o = 1'b1;
            ram_addr_o  = req_addr_i;
            ram_wdata_o = req_wdata_i;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RMW_RD: begin
        ram_req_o   = 1'b1;
        ram_write_o = 1'b1;
        ram_addr_o  = addr_r;
        ram_wdata_o = merged_s;
        state_s     = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, merge context and the reserved response slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r       <= IDLE;
      run_r         <= 1'b0;
      addr_r        <= {Aw{1'b0}};
      wdata_r       <= {Width{1'b0}};
      mask_r        <= {Mw{1'b0}};
      inflight_r    <= 1'b0;
      inflight_rd_r <= 1'b0;
    end else begin
      run_r         <= 1'b1;
      state_r       <= state_s;
      inflight_r    <= accept_s & need_rsp_s & ~partial_s;
      inflight_rd_r <= accept_s & ~req_write_i;
      if (accept_s && partial_s) begin
        addr_r  <= req_addr_i;
        wdata_r <= req_wdata_i;
        mask_r  <= req_wmask_i;
      end
    end
  end

  prim_ram_ctrl_rsp_fifo #(
    .Width(Width)
  ) u_rsp_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push_s),
    .push_data_i(push_data_s),
    .pop_i      (pop_s),
    .valid_o    (rsp_valid_o),
    .data_o     (rsp_rdata_o),
    .count_o    (count_s)
  );

endmodule
